// File: rtl/lock_pkg.sv
// Shared types and constants for the combination-lock core and its display.
package lock_pkg;
  typedef enum logic [1:0] {ENTRY, CHECK, OPEN, DENIED} lock_state_t;
  localparam int ATTEMPT_W = 2;
  localparam int IDX_W     = 3;
endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector on a debounced level: rise = din & ~din_q, with din_q registered every clock.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);
  logic din_q;

  // Reset loads 1 so a level held high across reset release reads as no edge.
  always_ff @(posedge clk) begin
    if (!rst_n) din_q <= 1'b1;
    else        din_q <= din;
  end

  assign rise = din & ~din_q;
endmodule

// File: rtl/lock_controller.sv
// Combination-lock FSM: collects CODE_LEN digits, compares with SECRET, tracks tries, drives done/fail/attempt.
module lock_controller
  import lock_pkg::*;
#(
  parameter int                          CODE_LEN    = 4,
  parameter int                          DIGIT_W     = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] SECRET      = 16'h1234,
  parameter int                          MAX_TRIES   = 3,
  parameter int                          OPEN_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIGIT_W-1:0]   digit_in,
  input  logic                 enter_btn,
  input  logic                 clear_btn,
  input  logic                 relock_btn,
  output logic                 done,
  output logic                 fail,
  output logic [ATTEMPT_W-1:0] attempt,
  output logic [IDX_W-1:0]     digit_idx
);
  localparam int CNT_W = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;

  function automatic logic [DIGIT_W-1:0] secret_digit(input logic [IDX_W-1:0] idx);
    return SECRET[(CODE_LEN - 1 - int'(idx)) * DIGIT_W +: DIGIT_W];
  endfunction

  lock_state_t          state_q, state_n;
  logic [IDX_W-1:0]     idx_q, idx_n;
  logic                 mismatch_q, mismatch_n;
  logic [CNT_W-1:0]     open_cnt_q, open_cnt_n;
  logic [ATTEMPT_W-1:0] attempt_q, attempt_n;
  logic                 done_q, fail_q;
  logic                 enter_rise;
  logic                 open_timeout;

  rise_detect u_enter_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (enter_btn),
    .rise  (enter_rise)
  );

  assign open_timeout = (OPEN_CYCLES > 0) && (open_cnt_q == CNT_W'(OPEN_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ENTRY;
      idx_q      <= '0;
      mismatch_q <= 1'b0;
      open_cnt_q <= '0;
      attempt_q  <= ATTEMPT_W'(MAX_TRIES);
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      idx_q      <= idx_n;
      mismatch_q <= mismatch_n;
      open_cnt_q <= open_cnt_n;
      attempt_q  <= attempt_n;
      done_q     <= (state_n == OPEN);
      fail_q     <= (state_n == DENIED);
    end
  end

  always_comb begin
    state_n    = state_q;
    idx_n      = idx_q;
    mismatch_n = mismatch_q;
    open_cnt_n = open_cnt_q;
    attempt_n  = attempt_q;
    unique case (state_q)
      ENTRY: begin
        // Clear wins over a simultaneous key press and never costs a try.
        if (clear_btn) begin
          idx_n      = '0;
          mismatch_n = 1'b0;
        end else if (enter_rise) begin
          mismatch_n = mismatch_q | (digit_in != secret_digit(idx_q));
          if (idx_q == IDX_W'(CODE_LEN - 1)) begin
            idx_n   = '0;
            state_n = CHECK;
          end else begin
            idx_n = idx_q + 1'b1;
          end
        end
      end
      CHECK: begin
        mismatch_n = 1'b0;
        if (!mismatch_q) begin
          state_n = OPEN;
        end else if (attempt_q > ATTEMPT_W'(1)) begin
          attempt_n = attempt_q - 1'b1;
          state_n   = ENTRY;
        end else begin
          attempt_n = '0;
          state_n   = DENIED;
        end
      end
      OPEN: begin
        if (relock_btn || open_timeout) begin
          state_n    = ENTRY;
          attempt_n  = ATTEMPT_W'(MAX_TRIES);
          open_cnt_n = '0;
        end else if (OPEN_CYCLES > 0) begin
          open_cnt_n = open_cnt_q + 1'b1;
        end
      end
      DENIED: begin
        attempt_n = '0;
      end
      default: state_n = ENTRY;
    endcase
  end

  assign done      = done_q;
  assign fail      = fail_q;
  assign attempt   = attempt_q;
  assign digit_idx = idx_q;
endmodule

// File: tb/tb_lock_controller.sv
// Directed bench for lock_controller (SECRET=1234, MAX_TRIES=3); a second instance uses OPEN_CYCLES=10.
module tb_lock_controller;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] digit_in = '0;
  logic       enter_btn = 1'b0;
  logic       clear_btn = 1'b0;
  logic       relock_btn = 1'b0;
  logic       done, fail, done2, fail2;
  logic [1:0] attempt, attempt2;
  logic [2:0] digit_idx, digit_idx2;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  lock_controller #(.CODE_LEN(4), .DIGIT_W(4), .SECRET(16'h1234), .MAX_TRIES(3), .OPEN_CYCLES(0)) dut (
    .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .enter_btn(enter_btn),
    .clear_btn(clear_btn), .relock_btn(relock_btn),
    .done(done), .fail(fail), .attempt(attempt), .digit_idx(digit_idx));

  lock_controller #(.CODE_LEN(4), .DIGIT_W(4), .SECRET(16'h1234), .MAX_TRIES(3), .OPEN_CYCLES(10)) dut2 (
    .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .enter_btn(enter_btn),
    .clear_btn(clear_btn), .relock_btn(relock_btn),
    .done(done2), .fail(fail2), .attempt(attempt2), .digit_idx(digit_idx2));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns one negedge after the clock edge that samples the rising edge.
  task automatic key(input logic [3:0] d);
    @(negedge clk); digit_in = d; enter_btn = 1'b1;
    @(negedge clk); enter_btn = 1'b0;
  endtask

  task automatic key_code(input logic [15:0] code);
    for (int i = 3; i >= 0; i--) key(code[i*4 +: 4]);
    @(negedge clk);
  endtask

  task automatic pulse_relock();
    @(negedge clk); relock_btn = 1'b1;
    @(negedge clk); relock_btn = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n_open;
    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_fail", {7'd0, fail}, 8'd0);
    chk("rst_attempt", {6'd0, attempt}, 8'd3);
    chk("rst_idx", {5'd0, digit_idx}, 8'd0);

    // Test 1: correct code, latency, relock
    key(4'h1); key(4'h2); key(4'h3);
    chk("t1_idx3", {5'd0, digit_idx}, 8'd3);
    key(4'h4);
    chk("t1_done_early", {7'd0, done}, 8'd0);
    chk("t1_idx_wrap", {5'd0, digit_idx}, 8'd0);
    @(negedge clk);
    chk("t1_done", {7'd0, done}, 8'd1);
    chk("t1_attempt", {6'd0, attempt}, 8'd3);
    chk("t1_fail", {7'd0, fail}, 8'd0);
    pulse_relock();
    chk("t1_relock_done", {7'd0, done}, 8'd0);
    chk("t1_relock_att", {6'd0, attempt}, 8'd3);

    // Test 2: wrong codes down to DENIED, buttons ignored
    key_code(16'h1235);
    chk("t2_att2", {6'd0, attempt}, 8'd2);
    chk("t2_done0", {7'd0, done}, 8'd0);
    key_code(16'h9234);
    chk("t2_att1", {6'd0, attempt}, 8'd1);
    key_code(16'h1204);
    chk("t2_fail", {7'd0, fail}, 8'd1);
    chk("t2_att0", {6'd0, attempt}, 8'd0);
    key_code(16'h1234);
    pulse_relock();
    chk("t2_stuck_fail", {7'd0, fail}, 8'd1);
    chk("t2_stuck_done", {7'd0, done}, 8'd0);
    chk("t2_stuck_att", {6'd0, attempt}, 8'd0);
    chk("t2_stuck_idx", {5'd0, digit_idx}, 8'd0);

    // Test 3: clear discards partial entry; clear beats a simultaneous key
    do_reset();
    key(4'h1); key(4'h2);
    chk("t3_idx2", {5'd0, digit_idx}, 8'd2);
    @(negedge clk); clear_btn = 1'b1;
    @(negedge clk); clear_btn = 1'b0;
    chk("t3_clr_idx", {5'd0, digit_idx}, 8'd0);
    chk("t3_clr_att", {6'd0, attempt}, 8'd3);
    key_code(16'h1234);
    chk("t3_done", {7'd0, done}, 8'd1);
    pulse_relock();
    @(negedge clk); clear_btn = 1'b1; enter_btn = 1'b1; digit_in = 4'h1;
    @(negedge clk); clear_btn = 1'b0; enter_btn = 1'b0;
    @(negedge clk);
    chk("t3_clr_enter_idx", {5'd0, digit_idx}, 8'd0);

    // Test 4: held enter counts once; enter held through reset gives no digit
    @(negedge clk); digit_in = 4'h1; enter_btn = 1'b1;
    repeat (20) @(negedge clk);
    chk("t4_held_idx", {5'd0, digit_idx}, 8'd1);
    enter_btn = 1'b0;
    @(negedge clk); rst_n = 1'b0; enter_btn = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_rst_held_idx", {5'd0, digit_idx}, 8'd0);
    enter_btn = 1'b0;

    // Test 5: auto-relock after exactly 10 OPEN clocks on dut2
    do_reset();
    key(4'h1); key(4'h2); key(4'h3); key(4'h4);
    n_open = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done2) n_open++;
    end
    chk("t5_open_clocks", n_open[7:0], 8'd10);
    chk("t5_done2_off", {7'd0, done2}, 8'd0);
    chk("t5_att2", {6'd0, attempt2}, 8'd3);
    chk("t5_dut_holds", {7'd0, done}, 8'd1);
    pulse_relock();

    // Test 6: reset mid-entry with a try consumed
    key_code(16'h1235);
    chk("t6_att2", {6'd0, attempt}, 8'd2);
    key(4'h1); key(4'h2);
    chk("t6_idx2", {5'd0, digit_idx}, 8'd2);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_att", {6'd0, attempt}, 8'd3);
    chk("t6_rst_idx", {5'd0, digit_idx}, 8'd0);
    chk("t6_rst_done", {7'd0, done}, 8'd0);
    chk("t6_rst_fail", {7'd0, fail}, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
